// File: rtl/id_ex_hazard_reg_if.sv
// Decode-to-EX bundle for the ID/EX hazard register: decode-side inputs, EX-slot outputs, status.
// No storage; latency belongs to the attached register.
// Stall_IF_ID travels back to the decode side as the backpressure signal.
// Ports (signals): ID_* decode fields, EX_busy/Branch_flush controls, ID_EX_* registered slot,
//   Stall_IF_ID, EX_state, Bubble_Cnt, Hold_Cnt.
interface id_ex_hazard_reg_if #(
  parameter int WIDTH_SOURCE = 5,
  parameter int CNT_WIDTH    = 16
);
  logic                    ID_valid;
  logic [WIDTH_SOURCE-1:0] ID_rs1;
  logic [WIDTH_SOURCE-1:0] ID_rs2;
  logic                    ID_rs1_used;
  logic                    ID_rs2_used;
  logic [WIDTH_SOURCE-1:0] ID_rd;
  logic                    ID_Reg_Wr;
  logic                    ID_Mem_Rd;
  logic                    ID_int_op;
  logic                    EX_busy;
  logic                    Branch_flush;

  logic                    ID_EX_valid;
  logic [WIDTH_SOURCE-1:0] ID_EX_rs1;
  logic [WIDTH_SOURCE-1:0] ID_EX_rs2;
  logic [WIDTH_SOURCE-1:0] ID_EX_rd;
  logic                    ID_EX_Reg_Wr;
  logic                    ID_EX_Mem_Rd;
  logic                    ID_EX_int_op;
  logic                    Stall_IF_ID;
  logic [1:0]              EX_state;
  logic [CNT_WIDTH-1:0]    Bubble_Cnt;
  logic [CNT_WIDTH-1:0]    Hold_Cnt;

  // Decode / pipeline-control side drives the ID_* fields.
  modport master (
    output ID_valid, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_rd,
           ID_Reg_Wr, ID_Mem_Rd, ID_int_op, EX_busy, Branch_flush,
    input  ID_EX_valid, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_Reg_Wr,
           ID_EX_Mem_Rd, ID_EX_int_op, Stall_IF_ID, EX_state, Bubble_Cnt, Hold_Cnt
  );

  // The hazard register consumes decode fields and produces the EX slot.
  modport slave (
    input  ID_valid, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_rd,
           ID_Reg_Wr, ID_Mem_Rd, ID_int_op, EX_busy, Branch_flush,
    output ID_EX_valid, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_Reg_Wr,
           ID_EX_Mem_Rd, ID_EX_int_op, Stall_IF_ID, EX_state, Bubble_Cnt, Hold_Cnt
  );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, EX_busy hold and branch flush.
// Latency: one cycle ID_* -> ID_EX_*; Stall_IF_ID is combinational in the hazard cycle.
// Backpressure: Stall_IF_ID freezes PC and IF/ID while EX is busy or a load-use bubble is inserted.
// Ports: CLK (rising edge), rst (synchronous, active high), bus (slave side of id_ex_hazard_reg_if).
module id_ex_hazard_reg #(
  parameter int WIDTH_SOURCE = 5,
  parameter int CNT_WIDTH    = 16
) (
  input  logic              CLK,
  input  logic              rst,
  id_ex_hazard_reg_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    BUBBLE = 2'b01,
    HOLD   = 2'b10
  } ex_state_e;

  ex_state_e               state_q, state_d;
  logic                    valid_q, valid_d;
  logic [WIDTH_SOURCE-1:0] rs1_q, rs1_d;
  logic [WIDTH_SOURCE-1:0] rs2_q, rs2_d;
  logic [WIDTH_SOURCE-1:0] rd_q, rd_d;
  logic                    reg_wr_q, reg_wr_d;
  logic                    mem_rd_q, mem_rd_d;
  logic                    int_op_q, int_op_d;
  logic [CNT_WIDTH-1:0]    bub_cnt_q, bub_cnt_d;
  logic [CNT_WIDTH-1:0]    hold_cnt_q, hold_cnt_d;
  logic                    load_use;

  // A load targeting x0 never produces a hazard: x0 is never really written.
  assign load_use = bus.ID_valid & valid_q & mem_rd_q & (rd_q != '0) &
                    ((bus.ID_rs1_used & (bus.ID_rs1 == rd_q)) |
                     (bus.ID_rs2_used & (bus.ID_rs2 == rd_q)));

  // A flush kills the decode instruction, so there is nothing left to hold back.
  assign bus.Stall_IF_ID = ~bus.Branch_flush & (bus.EX_busy | load_use);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    reg_wr_d   = reg_wr_q;
    mem_rd_d   = mem_rd_q;
    int_op_d   = int_op_q;
    bub_cnt_d  = bub_cnt_q;
    hold_cnt_d = hold_cnt_q;

    if (bus.Branch_flush) begin
      // Flush beats busy: the busy op is already in EX; only decode dies.
      state_d  = RUN;
      valid_d  = 1'b0;
      rs1_d    = '0;
      rs2_d    = '0;
      rd_d     = '0;
      reg_wr_d = 1'b0;
      mem_rd_d = 1'b0;
      int_op_d = 1'b0;
    end else if (bus.EX_busy) begin
      // Hold beats load_use; the hazard is re-evaluated once busy drops.
      state_d = HOLD;
      if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
    end else if (load_use) begin
      // Zeroed rd/rs keep the forwarding unit from matching the bubble.
      state_d  = BUBBLE;
      valid_d  = 1'b0;
      rs1_d    = '0;
      rs2_d    = '0;
      rd_d     = '0;
      reg_wr_d = 1'b0;
      mem_rd_d = 1'b0;
      int_op_d = 1'b0;
      if (bub_cnt_q != '1) bub_cnt_d = bub_cnt_q + 1'b1;
    end else begin
      state_d  = RUN;
      valid_d  = bus.ID_valid;
      rs1_d    = bus.ID_rs1;
      rs2_d    = bus.ID_rs2;
      rd_d     = bus.ID_rd;
      reg_wr_d = bus.ID_Reg_Wr & bus.ID_valid;
      mem_rd_d = bus.ID_Mem_Rd & bus.ID_valid;
      int_op_d = bus.ID_int_op & bus.ID_valid;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= RUN;
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      reg_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      int_op_q   <= 1'b0;
      bub_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      reg_wr_q   <= reg_wr_d;
      mem_rd_q   <= mem_rd_d;
      int_op_q   <= int_op_d;
      bub_cnt_q  <= bub_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.ID_EX_valid  = valid_q;
  assign bus.ID_EX_rs1    = rs1_q;
  assign bus.ID_EX_rs2    = rs2_q;
  assign bus.ID_EX_rd     = rd_q;
  assign bus.ID_EX_Reg_Wr = reg_wr_q;
  assign bus.ID_EX_Mem_Rd = mem_rd_q;
  assign bus.ID_EX_int_op = int_op_q;
  assign bus.EX_state     = state_q;
  assign bus.Bubble_Cnt   = bub_cnt_q;
  assign bus.Hold_Cnt     = hold_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: a 16-bit-counter instance and a 2-bit-counter instance share stimulus.
// Expected values come from a slot/counter reference model plus directed constants.
module tb_id_ex_hazard_reg;

  logic       CLK = 1'b0;
  logic       rst;
  logic       ID_valid, ID_rs1_used, ID_rs2_used, ID_Reg_Wr, ID_Mem_Rd, ID_int_op;
  logic [4:0] ID_rs1, ID_rs2, ID_rd;
  logic       EX_busy, Branch_flush;

  int errs   = 0;
  int checks = 0;

  // Reference model of the EX slot, state and raw (unsaturated) event counts.
  int m_valid, m_rs1, m_rs2, m_rd, m_wr, m_mrd, m_iop, m_state, m_bub, m_hold;
  bit m_known = 1'b0;

  always #5 CLK = ~CLK;

  id_ex_hazard_reg_if #(.WIDTH_SOURCE(5), .CNT_WIDTH(16)) bus_a ();
  id_ex_hazard_reg_if #(.WIDTH_SOURCE(5), .CNT_WIDTH(2))  bus_b ();

  assign bus_a.ID_valid = ID_valid;       assign bus_b.ID_valid = ID_valid;
  assign bus_a.ID_rs1 = ID_rs1;           assign bus_b.ID_rs1 = ID_rs1;
  assign bus_a.ID_rs2 = ID_rs2;           assign bus_b.ID_rs2 = ID_rs2;
  assign bus_a.ID_rs1_used = ID_rs1_used; assign bus_b.ID_rs1_used = ID_rs1_used;
  assign bus_a.ID_rs2_used = ID_rs2_used; assign bus_b.ID_rs2_used = ID_rs2_used;
  assign bus_a.ID_rd = ID_rd;             assign bus_b.ID_rd = ID_rd;
  assign bus_a.ID_Reg_Wr = ID_Reg_Wr;     assign bus_b.ID_Reg_Wr = ID_Reg_Wr;
  assign bus_a.ID_Mem_Rd = ID_Mem_Rd;     assign bus_b.ID_Mem_Rd = ID_Mem_Rd;
  assign bus_a.ID_int_op = ID_int_op;     assign bus_b.ID_int_op = ID_int_op;
  assign bus_a.EX_busy = EX_busy;         assign bus_b.EX_busy = EX_busy;
  assign bus_a.Branch_flush = Branch_flush; assign bus_b.Branch_flush = Branch_flush;

  id_ex_hazard_reg #(.WIDTH_SOURCE(5), .CNT_WIDTH(16)) u_dut_a (.CLK(CLK), .rst(rst), .bus(bus_a));
  id_ex_hazard_reg #(.WIDTH_SOURCE(5), .CNT_WIDTH(2))  u_dut_b (.CLK(CLK), .rst(rst), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic int model_lu();
    bit src_hit;
    src_hit = (ID_rs1_used && (int'(ID_rs1) == m_rd)) || (ID_rs2_used && (int'(ID_rs2) == m_rd));
    return (ID_valid && m_valid != 0 && m_mrd != 0 && m_rd != 0 && src_hit) ? 1 : 0;
  endfunction

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic mrd, input logic iop,
                       input logic busy, input logic flush, input logic r);
    ID_valid = v; ID_rs1 = r1; ID_rs1_used = u1; ID_rs2 = r2; ID_rs2_used = u2;
    ID_rd = rd; ID_Reg_Wr = wr; ID_Mem_Rd = mrd; ID_int_op = iop;
    EX_busy = busy; Branch_flush = flush; rst = r;
  endtask

  task automatic clear_slot();
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_wr = 0; m_mrd = 0; m_iop = 0;
  endtask

  // Called shortly after the falling edge with inputs already applied; returns just after the next falling edge.
  task automatic do_cycle();
    int lu, exp_stall;
    #1;
    lu = model_lu();
    exp_stall = (!Branch_flush && (EX_busy || lu != 0)) ? 1 : 0;
    if (m_known) begin
      chk("stall_a", 32'(bus_a.Stall_IF_ID), 32'(exp_stall));
      chk("stall_b", 32'(bus_b.Stall_IF_ID), 32'(exp_stall));
    end
    @(posedge CLK);
    if (rst) begin
      clear_slot(); m_state = 0; m_bub = 0; m_hold = 0; m_known = 1'b1;
    end else if (Branch_flush) begin
      clear_slot(); m_state = 0;
    end else if (EX_busy) begin
      m_state = 2; m_hold++;
    end else if (lu != 0) begin
      clear_slot(); m_state = 1; m_bub++;
    end else begin
      m_valid = ID_valid; m_rs1 = ID_rs1; m_rs2 = ID_rs2; m_rd = ID_rd;
      m_wr = ID_Reg_Wr & ID_valid; m_mrd = ID_Mem_Rd & ID_valid; m_iop = ID_int_op & ID_valid;
      m_state = 0;
    end
    #1;
    chk("valid_a", 32'(bus_a.ID_EX_valid), 32'(m_valid));
    chk("rs1_a", 32'(bus_a.ID_EX_rs1), 32'(m_rs1));
    chk("rs2_a", 32'(bus_a.ID_EX_rs2), 32'(m_rs2));
    chk("rd_a", 32'(bus_a.ID_EX_rd), 32'(m_rd));
    chk("regwr_a", 32'(bus_a.ID_EX_Reg_Wr), 32'(m_wr));
    chk("memrd_a", 32'(bus_a.ID_EX_Mem_Rd), 32'(m_mrd));
    chk("intop_a", 32'(bus_a.ID_EX_int_op), 32'(m_iop));
    chk("state_a", 32'(bus_a.EX_state), 32'(m_state));
    chk("bubcnt_a", 32'(bus_a.Bubble_Cnt), 32'(sat(m_bub, 16)));
    chk("holdcnt_a", 32'(bus_a.Hold_Cnt), 32'(sat(m_hold, 16)));
    chk("valid_b", 32'(bus_b.ID_EX_valid), 32'(m_valid));
    chk("rd_b", 32'(bus_b.ID_EX_rd), 32'(m_rd));
    chk("state_b", 32'(bus_b.EX_state), 32'(m_state));
    chk("bubcnt_b", 32'(bus_b.Bubble_Cnt), 32'(sat(m_bub, 2)));
    chk("holdcnt_b", 32'(bus_b.Hold_Cnt), 32'(sat(m_hold, 2)));
    @(negedge CLK);
  endtask

  task automatic reset_cycle();
    drive(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    do_cycle();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge CLK);

    // Reset with random inputs.
    reset_cycle();
    chk("rst_valid", 32'(bus_a.ID_EX_valid), 32'd0);
    chk("rst_state", 32'(bus_a.EX_state), 32'd0);
    chk("rst_bub", 32'(bus_a.Bubble_Cnt), 32'd0);
    chk("rst_hold", 32'(bus_a.Hold_Cnt), 32'd0);

    // Load x5 followed by a consumer of x5: one bubble, then capture.
    drive(1, 1, 0, 2, 0, 5, 1, 1, 1, 0, 0, 0); do_cycle();
    drive(1, 5, 1, 3, 0, 8, 1, 0, 1, 0, 0, 0);
    #1 chk("lu_stall", 32'(bus_a.Stall_IF_ID), 32'd1);
    do_cycle();
    chk("lu_valid", 32'(bus_a.ID_EX_valid), 32'd0);
    chk("lu_state", 32'(bus_a.EX_state), 32'd1);
    chk("lu_bub", 32'(bus_a.Bubble_Cnt), 32'd1);
    do_cycle();
    chk("lu_cap_rs1", 32'(bus_a.ID_EX_rs1), 32'd5);
    chk("lu_cap_state", 32'(bus_a.EX_state), 32'd0);

    // Load to x0 never stalls.
    reset_cycle();
    drive(1, 1, 0, 2, 0, 0, 1, 1, 1, 0, 0, 0); do_cycle();
    drive(1, 4, 0, 0, 1, 6, 1, 0, 1, 0, 0, 0);
    #1 chk("x0_stall", 32'(bus_a.Stall_IF_ID), 32'd0);
    do_cycle();
    chk("x0_bub", 32'(bus_a.Bubble_Cnt), 32'd0);

    // EX_busy for three cycles with a new instruction waiting.
    reset_cycle();
    drive(1, 1, 1, 2, 1, 7, 1, 0, 1, 0, 0, 0); do_cycle();
    drive(1, 3, 1, 4, 1, 9, 1, 0, 1, 1, 0, 0);
    #1 chk("busy_stall", 32'(bus_a.Stall_IF_ID), 32'd1);
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      chk("busy_rd_held", 32'(bus_a.ID_EX_rd), 32'd7);
    end
    chk("busy_hold", 32'(bus_a.Hold_Cnt), 32'd3);
    chk("busy_state", 32'(bus_a.EX_state), 32'd2);
    EX_busy = 1'b0;
    do_cycle();
    chk("busy_rel_rd", 32'(bus_a.ID_EX_rd), 32'd9);
    chk("busy_rel_state", 32'(bus_a.EX_state), 32'd0);

    // Flush together with load_use and EX_busy.
    reset_cycle();
    drive(1, 1, 0, 2, 0, 5, 1, 1, 1, 0, 0, 0); do_cycle();
    drive(1, 5, 1, 5, 1, 8, 1, 0, 1, 1, 1, 0);
    #1 chk("fl_stall", 32'(bus_a.Stall_IF_ID), 32'd0);
    do_cycle();
    chk("fl_valid", 32'(bus_a.ID_EX_valid), 32'd0);
    chk("fl_state", 32'(bus_a.EX_state), 32'd0);
    chk("fl_bub", 32'(bus_a.Bubble_Cnt), 32'd0);
    chk("fl_hold", 32'(bus_a.Hold_Cnt), 32'd0);

    // A self-dependent load repeated: a bubble every other cycle, five in total.
    reset_cycle();
    drive(1, 5, 1, 0, 0, 5, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) do_cycle();
    chk("sat_bub_b", 32'(bus_b.Bubble_Cnt), 32'd3);
    chk("sat_bub_a", 32'(bus_a.Bubble_Cnt), 32'd5);

    // Randomized traffic biased toward dependencies on the EX-slot destination.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] r1, r2;
      r1 = ($urandom_range(0, 2) == 0) ? 5'(m_rd) : 5'($urandom);
      r2 = ($urandom_range(0, 2) == 0) ? 5'(m_rd) : 5'($urandom);
      drive(1'($urandom_range(0, 4) != 0), r1, 1'($urandom), r2, 1'($urandom),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
            1'($urandom_range(0, 1) == 0), 1'($urandom),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 39) == 0));
      do_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
